// File: rtl/hls_tcdm_port_arbiter_if.sv
// Bundled TCDM request/response signals for N lanes. Lane k's fields sit at
// index k of each flattened vector.
interface hls_tcdm_port_arbiter_if #(
    parameter int unsigned N      = 1,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [N-1:0]        req;
    logic [N-1:0]        gnt;
    logic [N*ADDR_W-1:0] add;
    logic [N-1:0]        wen;
    logic [N*BE_W-1:0]   be;
    logic [N*DATA_W-1:0] data;
    logic [N*DATA_W-1:0] r_data;
    logic [N-1:0]        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/hls_tcdm_port_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among N_REQ requesters,
// with request locking and an in-order ID FIFO that routes responses back.
module hls_tcdm_port_arbiter #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    localparam int unsigned CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    hls_tcdm_port_arbiter_if.slave       slv,
    hls_tcdm_port_arbiter_if.master      mst,
    output logic [CNT_W-1:0]             outst_o,
    output logic                         err_o
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e           state_q;
    logic [ID_W-1:0]  win_q;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic             err_q, err_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ID_W-1:0]  fifo_q [MAX_OUTST];

    logic [ID_W-1:0]  rr_winner;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  head;
    logic             any_req;
    logic             full;
    logic             fifo_empty;
    logic             issue;
    logic             accept;
    logic             pop;
    logic             drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan from the highest offset down so the lowest offset at/after rr_ptr wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rr_winner = rr_ptr_q;
        any_req   = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int unsigned idx;
            idx = (int'(rr_ptr_q) + i) % N_REQ;
            if (slv.req[idx]) begin
                rr_winner = ID_W'(idx);
                any_req   = 1'b1;
            end
        end
    end

    assign sel        = (state_q == HOLD) ? win_q : rr_winner;
    assign full       = (outst_q == CNT_W'(MAX_OUTST));
    assign fifo_empty = (outst_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // Full blocks issue from IDLE even if a pop lands in the same cycle.
    assign issue  = !rst_i && ((state_q == HOLD) ? slv.req[win_q] : (any_req && !full));
    assign accept = issue && mst.gnt[0];
    assign pop    = !rst_i && mst.r_valid[0] && !fifo_empty;
    assign drop   = !rst_i && mst.r_valid[0] && fifo_empty;

    assign mst.req  = issue;
    assign mst.add  = slv.add[sel*ADDR_W +: ADDR_W];
    assign mst.wen  = slv.wen[sel];
    assign mst.be   = slv.be[sel*BE_W +: BE_W];
    assign mst.data = slv.data[sel*DATA_W +: DATA_W];

    always_comb begin
        slv.gnt     = '0;
        slv.r_valid = '0;
        slv.r_data  = '0;
        if (accept) begin
            slv.gnt[sel] = 1'b1;
        end
        if (pop) begin
            slv.r_valid[head]                 = 1'b1;
            slv.r_data[head*DATA_W +: DATA_W] = mst.r_data;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
        end

        outst_d = outst_q;
        case ({accept, pop})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop    ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        err_d    = err_q | drop;
    end

    // Lock the winner while the TCDM withholds grant; a dropped request releases it.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            win_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue && !accept) begin
                        state_q <= HOLD;
                        win_q   <= rr_winner;
                    end
                end
                HOLD: begin
                    if (accept || !slv.req[win_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage is not reset; occupancy is tracked by outst_q and the pointers.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

    assign outst_o = outst_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_hls_tcdm_port_arbiter.sv
// Directed bench for hls_tcdm_port_arbiter: two requesters, MAX_OUTST=4.
module tb_hls_tcdm_port_arbiter;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [2:0] outst_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    hls_tcdm_port_arbiter_if #(.N(2), .DATA_W(32), .ADDR_W(32)) slv_bus ();
    hls_tcdm_port_arbiter_if #(.N(1), .DATA_W(32), .ADDR_W(32)) mst_bus ();

    hls_tcdm_port_arbiter #(
        .N_REQ(2), .MAX_OUTST(4), .DATA_W(32), .ADDR_W(32)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .slv     (slv_bus),
        .mst     (mst_bus),
        .outst_o (outst_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rd);
        slv_bus.req     = req;
        mst_bus.gnt     = gnt;
        mst_bus.r_valid = rv;
        mst_bus.r_data  = rd;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        slv_bus.add    = {32'h0000_0200, 32'h0000_0100};
        slv_bus.wen    = 2'b01;
        slv_bus.be     = {4'hF, 4'h3};
        slv_bus.data   = {32'hDEAD_BEEF, 32'h1234_5678};
        drive(2'b00, 1'b0, 1'b0, 32'h0);

        // Reset: outputs forced low even with a request and grant present
        tick(); drive(2'b01, 1'b1, 1'b1, 32'h0); #4;
        check("rst_mst_req", mst_bus.req, 0);
        check("rst_slv_gnt", slv_bus.gnt, 0);
        check("rst_r_valid", slv_bus.r_valid, 0);
        tick(); rst_i = 1'b0; drive(2'b00, 1'b0, 1'b0, 32'h0); #4;
        check("rst_outst", outst_o, 0);
        check("rst_err", err_o, 0);

        // Single read from requester 0, answered next cycle
        tick(); drive(2'b01, 1'b1, 1'b0, 32'h0); #4;
        check("t1_mst_req", mst_bus.req, 1);
        check("t1_mst_add", mst_bus.add, 32'h100);
        check("t1_mst_wen", mst_bus.wen, 1);
        check("t1_mst_be", mst_bus.be, 4'h3);
        check("t1_slv_gnt", slv_bus.gnt, 2'b01);
        tick(); drive(2'b00, 1'b0, 1'b1, 32'hCAFE); #4;
        check("t1_outst_1", outst_o, 1);
        check("t1_r_valid", slv_bus.r_valid, 2'b01);
        check("t1_r_data", slv_bus.r_data, {32'h0, 32'h0000_CAFE});
        tick(); drive(2'b00, 1'b0, 1'b0, 32'h0); #4;
        check("t1_outst_0", outst_o, 0);

        // Both requesting, grant always high: rr_ptr is 1 after the previous accept
        tick(); drive(2'b11, 1'b1, 1'b0, 32'h0); #4;
        check("t2_gnt_a", slv_bus.gnt, 2'b10);
        check("t2_wen_wr", mst_bus.wen, 0);
        check("t2_data_wr", mst_bus.data, 32'hDEAD_BEEF);
        check("t2_be_wr", mst_bus.be, 4'hF);
        tick(); #4; check("t2_gnt_b", slv_bus.gnt, 2'b01);
        tick(); #4; check("t2_gnt_c", slv_bus.gnt, 2'b10);
        tick(); #4; check("t2_gnt_d", slv_bus.gnt, 2'b01);
        check("t2_outst_3", outst_o, 3);

        // FIFO full: issue blocked, and a same-cycle pop does not unblock it
        tick(); #4;
        check("t4_outst_4", outst_o, 4);
        check("t4_full_req", mst_bus.req, 0);
        check("t4_full_gnt", slv_bus.gnt, 0);
        tick(); drive(2'b11, 1'b1, 1'b1, 32'h11); #4;
        check("t4_pop_req", mst_bus.req, 0);
        check("t4_pop_rv", slv_bus.r_valid, 2'b10);
        check("t4_pop_data", slv_bus.r_data, {32'h11, 32'h0});
        tick(); drive(2'b11, 1'b1, 1'b0, 32'h0); #4;
        check("t4_outst_3", outst_o, 3);
        check("t4_resume_gnt", slv_bus.gnt, 2'b10);

        // Drain: responses routed in issue order 0,1,0,1
        tick(); drive(2'b00, 1'b0, 1'b1, 32'h22); #4;
        check("t4_outst_4b", outst_o, 4);
        check("dr_rv_a", slv_bus.r_valid, 2'b01);
        check("dr_data_a", slv_bus.r_data, {32'h0, 32'h22});
        tick(); drive(2'b00, 1'b0, 1'b1, 32'h33); #4;
        check("dr_rv_b", slv_bus.r_valid, 2'b10);
        tick(); drive(2'b00, 1'b0, 1'b1, 32'h44); #4;
        check("dr_rv_c", slv_bus.r_valid, 2'b01);
        tick(); drive(2'b00, 1'b0, 1'b1, 32'h55); #4;
        check("dr_rv_d", slv_bus.r_valid, 2'b10);
        check("dr_data_d", slv_bus.r_data, {32'h55, 32'h0});
        tick(); drive(2'b00, 1'b0, 1'b0, 32'h0); #4;
        check("dr_outst_0", outst_o, 0);
        check("dr_err_0", err_o, 0);

        // Locking: requester 1 wins with rr_ptr=0, then stays locked when 0 joins
        tick(); drive(2'b10, 1'b0, 1'b0, 32'h0); #4;
        check("t3_req_a", mst_bus.req, 1);
        check("t3_add_a", mst_bus.add, 32'h200);
        check("t3_gnt_a", slv_bus.gnt, 0);
        tick(); drive(2'b11, 1'b0, 1'b0, 32'h0); #4;
        check("t3_add_b", mst_bus.add, 32'h200);
        check("t3_gnt_b", slv_bus.gnt, 0);
        tick(); #4;
        check("t3_add_c", mst_bus.add, 32'h200);
        tick(); drive(2'b11, 1'b1, 1'b0, 32'h0); #4;
        check("t3_gnt_d", slv_bus.gnt, 2'b10);
        tick(); #4;
        check("t3_next_gnt", slv_bus.gnt, 2'b01);

        // Protocol violation: locked requester withdraws, lock released
        tick(); drive(2'b01, 1'b0, 1'b0, 32'h0); #4;
        check("pv_add", mst_bus.add, 32'h100);
        tick(); drive(2'b00, 1'b0, 1'b0, 32'h0); #4;
        check("pv_req_low", mst_bus.req, 0);
        tick(); drive(2'b10, 1'b1, 1'b0, 32'h0); #4;
        check("pv_gnt", slv_bus.gnt, 2'b10);
        check("pv_outst_2", outst_o, 2);

        // Interleaved responses to ports 1,0,1, then one with the FIFO empty
        tick(); drive(2'b00, 1'b0, 1'b1, 32'hD1); #4;
        check("t5_rv_1", slv_bus.r_valid, 2'b10);
        check("t5_data_1", slv_bus.r_data, {32'hD1, 32'h0});
        tick(); drive(2'b00, 1'b0, 1'b1, 32'hD2); #4;
        check("t5_rv_2", slv_bus.r_valid, 2'b01);
        check("t5_data_2", slv_bus.r_data, {32'h0, 32'hD2});
        tick(); drive(2'b00, 1'b0, 1'b1, 32'hD3); #4;
        check("t5_rv_3", slv_bus.r_valid, 2'b10);
        tick(); drive(2'b00, 1'b0, 1'b1, 32'hD4); #4;
        check("t5_outst_0", outst_o, 0);
        check("t5_drop_rv", slv_bus.r_valid, 0);
        check("t5_err_pre", err_o, 0);
        tick(); drive(2'b00, 1'b0, 1'b0, 32'h0); #4;
        check("t5_err", err_o, 1);

        // Reset with two outstanding, then a stray response
        tick(); drive(2'b11, 1'b1, 1'b0, 32'h0); #4;
        check("t6_gnt_a", slv_bus.gnt, 2'b01);
        tick(); #4;
        check("t6_gnt_b", slv_bus.gnt, 2'b10);
        tick(); rst_i = 1'b1; drive(2'b11, 1'b1, 1'b1, 32'hEE); #4;
        check("t6_outst_2", outst_o, 2);
        check("t6_rst_req", mst_bus.req, 0);
        check("t6_rst_gnt", slv_bus.gnt, 0);
        check("t6_rst_rv", slv_bus.r_valid, 0);
        tick(); rst_i = 1'b0; drive(2'b00, 1'b0, 1'b1, 32'hEE); #4;
        check("t6_outst_0", outst_o, 0);
        check("t6_err_clr", err_o, 0);
        check("t6_stray_rv", slv_bus.r_valid, 0);
        tick(); drive(2'b00, 1'b0, 1'b0, 32'h0); #4;
        check("t6_err", err_o, 1);
        check("t6_outst_end", outst_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
